// File: rtl/pla_toggle_monitor.sv
// -----------------------------------------------------------------------------
// pla_toggle_monitor
//   Observes the 12-output PLA stage (v10.0..v10.11) and measures switching
//   activity over a programmable window. After a start pulse it primes on the
//   first valid sample. It then counts per-bit toggles and the total toggle
//   count over win_len transitions, so the window spans win_len+1 samples.
//   Finally it streams the results to the power estimator as valid/ready beats.
//
//   Optional feature macro: PLA_TOGGLE_PEAK_HD_EN
//     When defined, the monitor also tracks the peak per-sample Hamming
//     distance and emits it as one extra, final beat (rpt_idx = N_BITS+1).
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, aborts any window/report
//   start      in   one-cycle pulse, begins a window (ignored when busy)
//   win_len    in   number of transitions to count, latched on accepted start
//   in_valid   in   in_vec carries a new PLA sample this cycle
//   in_vec     in   PLA outputs, bit i = v10.i
//   busy       out  high whenever the monitor is not idle
//   rpt_valid  out  report beat valid
//   rpt_ready  in   consumer accepts the current beat
//   rpt_idx    out  beat index: 0..N_BITS-1 per-bit count, N_BITS total
//   rpt_data   out  beat payload, zero-extended
// -----------------------------------------------------------------------------
module pla_toggle_monitor #(
    parameter int   N_BITS = 12,
    parameter int   CNT_W  = 16,
    parameter int   WIN_W  = 16,
    localparam int  IDX_W  = $clog2(N_BITS + 2),
    localparam int  TOT_W  = CNT_W + $clog2(N_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              in_valid,
    input  logic [N_BITS-1:0] in_vec,
    output logic              busy,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [IDX_W-1:0]  rpt_idx,
    output logic [TOT_W-1:0]  rpt_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_COUNT  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};
`ifdef PLA_TOGGLE_PEAK_HD_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS + 1);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS);
`endif

    // Number of ones in a sample difference (the Hamming distance).
    function automatic logic [IDX_W-1:0] f_popcount(input logic [N_BITS-1:0] v);
        logic [IDX_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_BITS; i++) begin
            acc = acc + {{(IDX_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    state_t             r_state;
    logic [N_BITS-1:0]  r_prev;
    logic [CNT_W-1:0]   r_cnt [N_BITS];
    logic [TOT_W-1:0]   r_total;
    logic [WIN_W-1:0]   r_remaining;
    logic               r_busy;
    logic               r_rpt_valid;
    logic [IDX_W-1:0]   r_rpt_idx;
    logic [TOT_W-1:0]   r_rpt_data;
`ifdef PLA_TOGGLE_PEAK_HD_EN
    logic [IDX_W-1:0]   r_peak;
    logic [IDX_W-1:0]   w_peak_nxt;
`endif

    state_t             w_state_nxt;
    logic [N_BITS-1:0]  w_prev_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt [N_BITS];
    logic [TOT_W-1:0]   w_total_nxt;
    logic [WIN_W-1:0]   w_remaining_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [N_BITS-1:0]  w_diff;
    logic [IDX_W-1:0]   w_pop;
    logic [TOT_W:0]     w_tot_sum;
    logic               w_start_ok;
    logic               w_beat_fire;
    logic [TOT_W-1:0]   w_beat_data;

    assign w_diff      = in_vec ^ r_prev;
    assign w_pop       = f_popcount(w_diff);
    assign w_tot_sum   = {1'b0, r_total} + {{(TOT_W+1-IDX_W){1'b0}}, w_pop};
    assign w_start_ok  = start && (win_len != {WIN_W{1'b0}});
    assign w_beat_fire = r_rpt_valid && rpt_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_PRIME;
                else            w_state_nxt = S_IDLE;
            end
            S_PRIME: begin
                if (in_valid) w_state_nxt = S_COUNT;
                else          w_state_nxt = S_PRIME;
            end
            S_COUNT: begin
                // remaining is never zero here, so 1 marks the last transition.
                if (in_valid && (r_remaining == WIN_W'(1))) w_state_nxt = S_REPORT;
                else                                       w_state_nxt = S_COUNT;
            end
            S_REPORT: begin
                if (w_beat_fire && (r_rpt_idx == LAST_IDX)) w_state_nxt = S_IDLE;
                else                                       w_state_nxt = S_REPORT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the counters, sample history and beat index.
    always_comb begin
        w_prev_nxt      = r_prev;
        w_cnt_nxt       = r_cnt;
        w_total_nxt     = r_total;
        w_remaining_nxt = r_remaining;
        w_idx_nxt       = r_rpt_idx;
`ifdef PLA_TOGGLE_PEAK_HD_EN
        w_peak_nxt      = r_peak;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    for (int i = 0; i < N_BITS; i++) begin
                        w_cnt_nxt[i] = '0;
                    end
                    w_total_nxt     = '0;
                    w_remaining_nxt = win_len;
                    w_idx_nxt       = '0;
`ifdef PLA_TOGGLE_PEAK_HD_EN
                    w_peak_nxt      = '0;
`endif
                end else begin
                    w_remaining_nxt = r_remaining;
                end
            end
            S_PRIME: begin
                if (in_valid) w_prev_nxt = in_vec;
                else          w_prev_nxt = r_prev;
            end
            S_COUNT: begin
                if (in_valid) begin
                    for (int i = 0; i < N_BITS; i++) begin
                        if (w_diff[i] && (r_cnt[i] != CNT_MAX)) begin
                            w_cnt_nxt[i] = r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i];
                        end
                    end
                    // Carry out of the widened sum means the total saturates.
                    w_total_nxt     = w_tot_sum[TOT_W] ? TOT_MAX : w_tot_sum[TOT_W-1:0];
                    w_prev_nxt      = in_vec;
                    w_remaining_nxt = r_remaining - WIN_W'(1);
`ifdef PLA_TOGGLE_PEAK_HD_EN
                    if (w_pop > r_peak) w_peak_nxt = w_pop;
                    else                w_peak_nxt = r_peak;
`endif
                end else begin
                    w_prev_nxt = r_prev;
                end
            end
            S_REPORT: begin
                if (w_beat_fire) begin
                    w_idx_nxt = (r_rpt_idx == LAST_IDX) ? {IDX_W{1'b0}}
                                                        : r_rpt_idx + IDX_W'(1);
                end else begin
                    w_idx_nxt = r_rpt_idx;
                end
            end
            default: w_idx_nxt = r_rpt_idx;
        endcase
    end

    // Payload of the beat that will be presented next cycle; it is built from
    // the next-cycle counter values so the first beat already includes the
    // final counted sample.
    always_comb begin
        w_beat_data = '0;
        if (w_state_nxt == S_REPORT) begin
            for (int i = 0; i < N_BITS; i++) begin
                if (w_idx_nxt == IDX_W'(i)) begin
                    w_beat_data = {{(TOT_W-CNT_W){1'b0}}, w_cnt_nxt[i]};
                end else begin
                    w_beat_data = w_beat_data;
                end
            end
            if (w_idx_nxt == IDX_W'(N_BITS)) w_beat_data = w_total_nxt;
            else                             w_beat_data = w_beat_data;
`ifdef PLA_TOGGLE_PEAK_HD_EN
            if (w_idx_nxt == IDX_W'(N_BITS + 1)) w_beat_data = {{(TOT_W-IDX_W){1'b0}}, w_peak_nxt};
            else                                 w_beat_data = w_beat_data;
`endif
        end else begin
            w_beat_data = '0;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= '0;
            for (int i = 0; i < N_BITS; i++) begin
                r_cnt[i] <= '0;
            end
            r_total     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_idx   <= '0;
            r_rpt_data  <= '0;
`ifdef PLA_TOGGLE_PEAK_HD_EN
            r_peak      <= '0;
`endif
        end else begin
            r_prev      <= w_prev_nxt;
            r_cnt       <= w_cnt_nxt;
            r_total     <= w_total_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_rpt_valid <= (w_state_nxt == S_REPORT);
            r_rpt_idx   <= w_idx_nxt;
            r_rpt_data  <= w_beat_data;
`ifdef PLA_TOGGLE_PEAK_HD_EN
            r_peak      <= w_peak_nxt;
`endif
        end
    end

    assign busy      = r_busy;
    assign rpt_valid = r_rpt_valid;
    assign rpt_idx   = r_rpt_idx;
    assign rpt_data  = r_rpt_data;

endmodule

// File: tb/tb_pla_toggle_monitor.sv
// -----------------------------------------------------------------------------
// tb_pla_toggle_monitor
//   Two monitors (CNT_W=16 and CNT_W=4) share every input. A window-level model
//   derives per-bit toggle counts, total and peak directly from the sample list.
//   A single negedge compare process then follows each report beat by beat.
// -----------------------------------------------------------------------------
module tb_pla_toggle_monitor;

    localparam int N_BITS = 12;
    localparam int WIN_W  = 16;
    localparam int IDX_W  = 4;
    localparam int TOT_A  = 20;
    localparam int TOT_B  = 8;
`ifdef PLA_TOGGLE_PEAK_HD_EN
    localparam int N_BEATS = 14;
`else
    localparam int N_BEATS = 13;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIN_W-1:0]  win_len = '0;
    logic              in_valid = 1'b0;
    logic [N_BITS-1:0] in_vec = '0;
    logic              rpt_ready = 1'b1;

    logic              a_busy, a_rpt_valid, b_busy, b_rpt_valid;
    logic [IDX_W-1:0]  a_rpt_idx, b_rpt_idx;
    logic [TOT_A-1:0]  a_rpt_data;
    logic [TOT_B-1:0]  b_rpt_data;

    pla_toggle_monitor #(.N_BITS(12), .CNT_W(16), .WIN_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(a_busy),
        .rpt_valid(a_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(a_rpt_idx), .rpt_data(a_rpt_data)
    );

    pla_toggle_monitor #(.N_BITS(12), .CNT_W(4), .WIN_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_vec(in_vec), .busy(b_busy),
        .rpt_valid(b_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(b_rpt_idx), .rpt_data(b_rpt_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [N_BITS-1:0] smp [$];
    int  exp_a [0:13];
    int  exp_b [0:13];
    bit  exp_rpt   = 1'b0;
    bit  exp_busy  = 1'b0;
    bit  rpt_done  = 1'b0;
    bit  armed     = 1'b0;
    bit  rst_seen  = 1'b0;
    int  beat_ptr  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: counts come straight from the sample list.
    task automatic build_model();
        int tog [N_BITS];
        int tot, peak, pk;
        logic [N_BITS-1:0] d;
        tot = 0; peak = 0;
        for (int i = 0; i < N_BITS; i++) tog[i] = 0;
        for (int k = 1; k < smp.size(); k++) begin
            d  = smp[k] ^ smp[k-1];
            pk = $countones(d);
            tot += pk;
            if (pk > peak) peak = pk;
            for (int i = 0; i < N_BITS; i++) if (d[i]) tog[i]++;
        end
        for (int i = 0; i < N_BITS; i++) begin
            exp_a[i] = (tog[i] > 65535) ? 65535 : tog[i];
            exp_b[i] = (tog[i] > 15) ? 15 : tog[i];
        end
        exp_a[N_BITS]   = (tot > 1048575) ? 1048575 : tot;
        exp_b[N_BITS]   = (tot > 255) ? 255 : tot;
        exp_a[N_BITS+1] = peak;
        exp_b[N_BITS+1] = peak;
    endtask

    always @(posedge clk) rst_seen <= rst;

    // Compare process: outputs checked every cycle against the model.
    always @(negedge clk) begin
        if (rst_seen) begin
            armed = 1'b1;
            check("rst_busy_a",  a_busy, 0);
            check("rst_valid_a", a_rpt_valid, 0);
            check("rst_idx_a",   a_rpt_idx, 0);
            check("rst_data_a",  a_rpt_data, 0);
            check("rst_busy_b",  b_busy, 0);
            check("rst_valid_b", b_rpt_valid, 0);
            check("rst_data_b",  b_rpt_data, 0);
            exp_rpt  = 1'b0;
            exp_busy = 1'b0;
            beat_ptr = 0;
        end else if (armed) begin
            check("busy_a",  a_busy, exp_busy);
            check("busy_b",  b_busy, exp_busy);
            check("valid_a", a_rpt_valid, exp_rpt);
            check("valid_b", b_rpt_valid, exp_rpt);
            if (exp_rpt) begin
                check("idx_a",  a_rpt_idx, beat_ptr);
                check("data_a", a_rpt_data, exp_a[beat_ptr]);
                check("idx_b",  b_rpt_idx, beat_ptr);
                check("data_b", b_rpt_data, exp_b[beat_ptr]);
                if (rpt_ready) begin
                    if (beat_ptr == N_BEATS - 1) begin
                        exp_rpt  = 1'b0;
                        exp_busy = 1'b0;
                        rpt_done = 1'b1;
                        beat_ptr = 0;
                    end else begin
                        beat_ptr++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one window over smp (smp.size() must be wl+1) and drains the report.
    task automatic run_window(input int wl, input bit toggle_ready, input bit bubbles, input bit poke);
        build_model();
        rpt_done  = 1'b0;
        rpt_ready = 1'b1;
        start     = 1'b1;
        win_len   = WIN_W'(wl);
        tick();
        start     = 1'b0;
        win_len   = 16'hFFFF;
        exp_busy  = 1'b1;
        for (int k = 0; k <= wl; k++) begin
            in_valid = 1'b1;
            in_vec   = smp[k];
            if (poke && k == 1) begin
                start   = 1'b1;
                win_len = 16'd2;
            end
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
            if (k == wl) exp_rpt = 1'b1;
            if (bubbles && k < wl) begin
                in_vec = N_BITS'($urandom);
                tick();
            end
        end
        for (int c = 0; c < 200 && !rpt_done; c++) begin
            if (toggle_ready) rpt_ready = ~rpt_ready;
            tick();
        end
        check("report_done", rpt_done, 1);
        if (!rpt_done) begin
            exp_rpt  = 1'b0;
            exp_busy = 1'b0;
            beat_ptr = 0;
        end
        rpt_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // start with win_len==0 must be ignored.
        start   = 1'b1;
        win_len = 16'd0;
        tick();
        start   = 1'b0;
        tick();
        tick();

        // Basic window.
        smp = {};
        smp.push_back(12'h000); smp.push_back(12'h001);
        smp.push_back(12'h000); smp.push_back(12'h003);
        run_window(3, 1'b0, 1'b0, 1'b0);
        check("pin_t2_cnt0",  exp_a[0], 3);
        check("pin_t2_cnt1",  exp_a[1], 1);
        check("pin_t2_total", exp_a[12], 4);

        // Same window back-to-back, ready toggling, bubbles and a start while busy.
        run_window(3, 1'b1, 1'b1, 1'b1);

        // Alternating 000/FFF: the 4-bit counters saturate.
        smp = {};
        for (int k = 0; k <= 20; k++) smp.push_back((k % 2 == 0) ? 12'h000 : 12'hFFF);
        run_window(20, 1'b0, 1'b0, 1'b0);
        check("pin_t4_cnt_b",   exp_b[5], 15);
        check("pin_t4_total_b", exp_b[12], 240);
        check("pin_t4_cnt_a",   exp_a[0], 20);

        // Longer run: the 8-bit total of the narrow monitor saturates too.
        smp = {};
        for (int k = 0; k <= 25; k++) smp.push_back((k % 2 == 0) ? 12'h000 : 12'hFFF);
        run_window(25, 1'b1, 1'b0, 1'b0);
        check("pin_tsat_total_b", exp_b[12], 255);
        check("pin_tsat_total_a", exp_a[12], 300);

        // Abort in COUNT after two samples.
        start   = 1'b1;
        win_len = 16'd3;
        tick();
        start    = 1'b0;
        exp_busy = 1'b1;
        in_valid = 1'b1;
        in_vec   = 12'h000;
        tick();
        in_vec   = 12'h00F;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        tick();
        tick();
        smp = {};
        smp.push_back(12'h800); smp.push_back(12'h000);
        run_window(1, 1'b0, 1'b0, 1'b0);
        check("pin_t5_cnt11", exp_a[11], 1);
        check("pin_t5_total", exp_a[12], 1);

        // Peak Hamming distance window.
        smp = {};
        smp.push_back(12'h000); smp.push_back(12'h0FF); smp.push_back(12'h0FE);
        run_window(2, 1'b0, 1'b0, 1'b0);
        check("pin_t6_total", exp_a[12], 9);
`ifdef PLA_TOGGLE_PEAK_HD_EN
        check("pin_t6_peak", exp_a[13], 8);
`endif
        tick();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
